// File: rtl/firc_pkg.sv
// Shared widths, types and helpers for the complex FIR filter input feeder.
package firc_pkg;

  localparam int COEF_W    = 27;
  localparam int SAMP_W    = 24;
  localparam int ADDR_W    = 5;
  localparam int NCOEF_DEF = 15;
  localparam int TBL_SIZE  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    GAP    = 2'd2,
    STREAM = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic [SAMP_W-1:0] i;
    logic [SAMP_W-1:0] q;
  } samp_t;

  typedef struct packed {
    logic [COEF_W-1:0] i;
    logic [COEF_W-1:0] q;
  } coef_t;

  // Address 0 and anything past the last loaded coefficient are not part of the table.
  function automatic logic addr_in_table(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] last);
    return (addr != '0) && (addr <= last);
  endfunction

endpackage

// File: rtl/firc_sfifo.sv
// Synchronous sample FIFO; head is the oldest entry, visible one cycle after the write.
module firc_sfifo
  import firc_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              push,
  input  logic              pop,
  input  logic [SAMP_W-1:0] din_i,
  input  logic [SAMP_W-1:0] din_q,
  output logic [SAMP_W-1:0] head_i,
  output logic [SAMP_W-1:0] head_q,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  samp_t         mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;
  samp_t         head_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == '0);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head_s    = mem_r[rd_ptr_r];
  assign head_i    = head_s.i;
  assign head_q    = head_s.q;

  // Storage, power-of-two pointers that wrap naturally, and occupancy count
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        mem_r[e] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {din_i, din_q};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/firc_feeder.sv
// Replays the host coefficient table to the FIR filter as a PushCoef burst on Start,
// then streams buffered I/Q samples over the PushIn/StopIn handshake.
module firc_feeder
  import firc_pkg::*;
#(
  parameter int NCOEF      = NCOEF_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CfgWe,
  input  logic [ADDR_W-1:0] CfgAddr,
  input  logic [COEF_W-1:0] CfgI,
  input  logic [COEF_W-1:0] CfgQ,
  input  logic              Start,
  input  logic              SrcValid,
  output logic              SrcReady,
  input  logic [SAMP_W-1:0] SrcI,
  input  logic [SAMP_W-1:0] SrcQ,
  output logic              PushCoef,
  output logic [ADDR_W-1:0] CoefAddr,
  output logic [COEF_W-1:0] CoefI,
  output logic [COEF_W-1:0] CoefQ,
  output logic              PushIn,
  input  logic              StopIn,
  output logic [SAMP_W-1:0] SampI,
  output logic [SAMP_W-1:0] SampQ,
  output logic              Busy,
  output logic              CoefDone
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCOEF);

  feeder_state_t     state_r;
  coef_t             table_r [TBL_SIZE];
  coef_t             coef_r;
  logic [ADDR_W-1:0] coef_addr_r;
  logic [ADDR_W-1:0] next_addr_s;
  logic              push_coef_r;
  logic              busy_r;
  logic              coef_done_r;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_in_s;

  assign next_addr_s = coef_addr_r + ADDR_ONE;

  // Host coefficient table; the burst reads it at the same edge, so a colliding write shows up next burst
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int a = 0; a < TBL_SIZE; a++) begin
        table_r[a] <= '0;
      end
    end else if (CfgWe && addr_in_table(CfgAddr, LAST_ADDR)) begin
      table_r[CfgAddr] <= {CfgI, CfgQ};
    end
  end

  // Sequencer: burst of NCOEF coefficients, one quiet cycle, then sample streaming
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      push_coef_r <= 1'b0;
      coef_addr_r <= '0;
      coef_r      <= '0;
      busy_r      <= 1'b0;
      coef_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE, STREAM: begin
          if (Start) begin
            state_r     <= LOAD;
            push_coef_r <= 1'b1;
            coef_addr_r <= ADDR_ONE;
            coef_r      <= table_r[1];
            busy_r      <= 1'b1;
            coef_done_r <= 1'b0;
          end
        end
        LOAD: begin
          if (coef_addr_r == LAST_ADDR) begin
            state_r     <= GAP;
            push_coef_r <= 1'b0;
          end else begin
            coef_addr_r <= next_addr_s;
            coef_r      <= table_r[next_addr_s];
          end
        end
        GAP: begin
          state_r     <= STREAM;
          busy_r      <= 1'b0;
          coef_done_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          push_coef_r <= 1'b0;
          busy_r      <= 1'b0;
          coef_done_r <= 1'b0;
        end
      endcase
    end
  end

  // StopIn gates the push in the same cycle, leaving the head untouched
  assign push_in_s = (state_r == STREAM) && !fifo_empty_s && !StopIn;

  assign SrcReady = !fifo_full_s && !Reset;
  assign PushIn   = push_in_s;
  assign PushCoef = push_coef_r;
  assign CoefAddr = coef_addr_r;
  assign CoefI    = coef_r.i;
  assign CoefQ    = coef_r.q;
  assign Busy     = busy_r;
  assign CoefDone = coef_done_r;

  firc_sfifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (SrcValid),
    .pop   (push_in_s),
    .din_i (SrcI),
    .din_q (SrcQ),
    .head_i(SampI),
    .head_q(SampQ),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_firc_feeder.sv
// Directed bench for firc_feeder: timeline/queue reference model checked every cycle,
// plus literal expectations on burst timing, data and sample ordering.
module tb_firc_feeder;

  localparam int NC  = 15;
  localparam int DEP = 8;

  logic        Clk = 1'b0;
  logic        Reset, CfgWe, Start, SrcValid, StopIn;
  logic [4:0]  CfgAddr;
  logic [26:0] CfgI, CfgQ;
  logic [23:0] SrcI, SrcQ;
  logic        SrcReady, PushCoef, PushIn, Busy, CoefDone;
  logic [4:0]  CoefAddr;
  logic [26:0] CoefI, CoefQ;
  logic [23:0] SampI, SampQ;

  always #5 Clk = ~Clk;

  firc_feeder #(.NCOEF(NC), .FIFO_DEPTH(DEP)) dut (
    .Clk(Clk), .Reset(Reset), .CfgWe(CfgWe), .CfgAddr(CfgAddr), .CfgI(CfgI), .CfgQ(CfgQ),
    .Start(Start), .SrcValid(SrcValid), .SrcReady(SrcReady), .SrcI(SrcI), .SrcQ(SrcQ),
    .PushCoef(PushCoef), .CoefAddr(CoefAddr), .CoefI(CoefI), .CoefQ(CoefQ),
    .PushIn(PushIn), .StopIn(StopIn), .SampI(SampI), .SampQ(SampQ),
    .Busy(Busy), .CoefDone(CoefDone)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: coefficient channel derived from the cycle offset since the last
  // accepted Start; samples kept in a plain queue.
  int          cyc = 0;
  int          start_cycle = -1;
  bit          mvalid = 1'b0;
  logic [26:0] mt_i [32];
  logic [26:0] mt_q [32];
  logic [47:0] sq [$];
  logic [4:0]  e_addr;
  logic [26:0] e_ci, e_cq;
  int          off, nxt;
  bit          e_pc, e_busy, e_done, e_pi, m_acc;

  initial begin : model
    forever begin
      @(negedge Clk);
      #2;
      off    = cyc - start_cycle;
      e_pc   = (start_cycle >= 0) && (off >= 1) && (off <= NC);
      e_busy = (start_cycle >= 0) && (off >= 1) && (off <= NC + 1);
      e_done = (start_cycle >= 0) && (off >= NC + 2);
      e_pi   = e_done && (sq.size() != 0) && !StopIn;
      if (Reset) begin
        chk("src_ready_in_reset", 64'(SrcReady), 64'd0);
      end else if (mvalid) begin
        chk("push_coef", 64'(PushCoef), 64'(e_pc));
        chk("coef_addr", 64'(CoefAddr), 64'(e_addr));
        chk("coef_i", 64'(CoefI), 64'(e_ci));
        chk("coef_q", 64'(CoefQ), 64'(e_cq));
        chk("busy", 64'(Busy), 64'(e_busy));
        chk("coef_done", 64'(CoefDone), 64'(e_done));
        chk("src_ready", 64'(SrcReady), 64'(sq.size() < DEP));
        chk("push_in", 64'(PushIn), 64'(e_pi));
        if (sq.size() != 0) begin
          chk("samp_i", 64'(SampI), 64'(sq[0][47:24]));
          chk("samp_q", 64'(SampQ), 64'(sq[0][23:0]));
        end
      end
      if (Reset) begin
        mvalid      = 1'b1;
        start_cycle = -1;
        sq.delete();
        for (int a = 0; a < 32; a++) begin
          mt_i[a] = 27'd0;
          mt_q[a] = 27'd0;
        end
        e_addr = 5'd0;
        e_ci   = 27'd0;
        e_cq   = 27'd0;
      end else if (mvalid) begin
        m_acc = SrcValid && (sq.size() < DEP);
        if (e_pi) void'(sq.pop_front());
        if (m_acc) sq.push_back({SrcI, SrcQ});
        nxt = off + 1;
        if ((start_cycle >= 0) && (nxt >= 1) && (nxt <= NC)) begin
          e_addr = 5'(nxt);
          e_ci   = mt_i[nxt];
          e_cq   = mt_q[nxt];
        end
        if (Start && !e_busy) begin
          start_cycle = cyc;
          e_addr      = 5'd1;
          e_ci        = mt_i[1];
          e_cq        = mt_q[1];
        end
        if (CfgWe && (CfgAddr >= 5'd1) && (CfgAddr <= 5'(NC))) begin
          mt_i[CfgAddr] = CfgI;
          mt_q[CfgAddr] = CfgQ;
        end
      end
      cyc++;
    end
  end

  // Stimulus side: expected sample order is simply the order the bench handed samples in.
  logic [23:0] exp_q [$];
  bit          last_acc, last_push;
  int          delivered = 0;

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic step(input logic v, input logic [23:0] si, input logic stop, input logic st);
    tick();
    Reset = 1'b0; CfgWe = 1'b0; Start = st; StopIn = stop;
    SrcValid = v; SrcI = si; SrcQ = 24'd0 - si;
    #1;
    last_acc  = v && SrcReady;
    last_push = PushIn;
    if (PushIn) begin
      if (exp_q.size() == 0) chk("push_without_sample", 64'(PushIn), 64'd0);
      else begin
        chk("delivery_order", 64'(SampI), 64'(exp_q.pop_front()));
        delivered++;
      end
    end
    if (last_acc) exp_q.push_back(si);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [26:0] ci, input logic [26:0] cq);
    tick();
    Reset = 1'b0; Start = 1'b0; SrcValid = 1'b0; StopIn = 1'b0;
    CfgWe = 1'b1; CfgAddr = a; CfgI = ci; CfgQ = cq;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) step(1'b0, 24'd0, 1'b0, 1'b0);
    chk("drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_burst(input logic [26:0] ei1, input logic [26:0] eq1,
                           input logic [26:0] eq15, input bit mid_write);
    int npc;
    npc = 0;
    step(1'b0, 24'd0, 1'b0, 1'b1);
    for (int j = 1; j <= 17; j++) begin
      step(1'b0, 24'd0, 1'b0, 1'b0);
      if (PushCoef) npc++;
      if (j == 1) begin
        chk("burst_first_addr", 64'(CoefAddr), 64'd1);
        chk("burst_first_i", 64'(CoefI), 64'(ei1));
        chk("burst_first_q", 64'(CoefQ), 64'(eq1));
      end
      if (mid_write && j == 2) begin
        CfgWe = 1'b1; CfgAddr = 5'd3; CfgI = 27'h55; CfgQ = 27'h66;
      end
      if (mid_write && j == 3) begin
        chk("collide_addr", 64'(CoefAddr), 64'd3);
        chk("collide_old_i", 64'(CoefI), 64'd0);
      end
      if (j == 15) begin
        chk("burst_last_addr", 64'(CoefAddr), 64'd15);
        chk("burst_last_q", 64'(CoefQ), 64'(eq15));
      end
      if (j == 16) begin
        chk("gap_push_coef", 64'(PushCoef), 64'd0);
        chk("gap_busy", 64'(Busy), 64'd1);
        chk("gap_coef_done", 64'(CoefDone), 64'd0);
      end
      if (j == 17) begin
        chk("stream_coef_done", 64'(CoefDone), 64'd1);
        chk("stream_busy", 64'(Busy), 64'd0);
      end
    end
    chk("push_coef_cycles", 64'(npc), 64'd15);
  endtask

  int n, acc, quiet;

  initial begin
    Reset = 1'b1; CfgWe = 1'b0; CfgAddr = 5'd0; CfgI = 27'd0; CfgQ = 27'd0;
    Start = 1'b0; SrcValid = 1'b0; SrcI = 24'd0; SrcQ = 24'd0; StopIn = 1'b0;
    repeat (3) tick();
    step(1'b0, 24'd0, 1'b0, 1'b0);
    chk("rst_push_coef", 64'(PushCoef), 64'd0);
    chk("rst_coef_addr", 64'(CoefAddr), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_coef_done", 64'(CoefDone), 64'd0);
    chk("rst_src_ready", 64'(SrcReady), 64'd1);
    chk("rst_push_in", 64'(PushIn), 64'd0);

    for (int k = 1; k <= 15; k++) cfg_write(5'(k), 27'(k), 27'h7000000 - 27'(k));
    step(1'b0, 24'd0, 1'b0, 1'b0);
    run_burst(27'd1, 27'h6FFFFFF, 27'h6FFFFF1, 1'b0);

    // Out-of-table writes must not disturb the burst
    cfg_write(5'd0, 27'h1234567, 27'h1234567);
    cfg_write(5'd16, 27'h1234567, 27'h1234567);
    step(1'b0, 24'd0, 1'b0, 1'b0);
    run_burst(27'd1, 27'h6FFFFFF, 27'h6FFFFF1, 1'b0);

    // Free-flowing stream of 20 samples
    delivered = 0;
    step(1'b1, 24'd1, 1'b0, 1'b0);
    chk("first_accept", 64'(last_acc), 64'd1);
    chk("no_push_on_accept_cycle", 64'(last_push), 64'd0);
    step(1'b1, 24'd2, 1'b0, 1'b0);
    chk("first_push_next_cycle", 64'(last_push), 64'd1);
    n = last_acc ? 3 : 2;
    for (int c = 0; c < 60 && n <= 20; c++) begin
      step(1'b1, 24'(n), 1'b0, 1'b0);
      if (last_acc) n++;
    end
    chk("all_20_accepted", 64'(n), 64'd21);
    drain();
    chk("delivered_20", 64'(delivered), 64'd20);

    // Backpressure: FIFO fills at 8 while StopIn is held
    delivered = 0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      step(acc < 10, 24'(101 + acc), 1'b1, 1'b0);
      if (last_acc) acc++;
      chk("stop_no_push", 64'(last_push), 64'd0);
    end
    chk("accepts_until_full", 64'(acc), 64'd8);
    chk("src_ready_when_full", 64'(SrcReady), 64'd0);
    for (int c = 0; c < 20 && acc < 10; c++) begin
      step(1'b1, 24'(101 + acc), 1'b0, 1'b0);
      if (last_acc) acc++;
    end
    drain();
    chk("delivered_10", 64'(delivered), 64'd10);

    // Reload while samples are queued: they wait out LOAD and GAP
    for (int k = 0; k < 3; k++) step(1'b1, 24'(201 + k), 1'b1, 1'b0);
    step(1'b0, 24'd0, 1'b1, 1'b1);
    quiet = 0;
    for (int j = 1; j <= 16; j++) begin
      step(1'b0, 24'd0, 1'b0, 1'b0);
      if (!last_push) quiet++;
    end
    chk("quiet_during_reload", 64'(quiet), 64'd16);
    step(1'b0, 24'd0, 1'b0, 1'b0);
    chk("resume_push", 64'(last_push), 64'd1);
    chk("resume_head", 64'(SampI), 64'd201);
    drain();

    // Reset in the middle of a burst discards FIFO and table
    step(1'b1, 24'd301, 1'b1, 1'b0);
    step(1'b1, 24'd302, 1'b1, 1'b0);
    step(1'b0, 24'd0, 1'b1, 1'b1);
    for (int j = 1; j <= 7; j++) step(1'b0, 24'd0, 1'b1, 1'b0);
    chk("load_at_k7", 64'(CoefAddr), 64'd7);
    Reset = 1'b1;
    exp_q.delete();
    step(1'b0, 24'd0, 1'b0, 1'b0);
    chk("mid_rst_push_coef", 64'(PushCoef), 64'd0);
    chk("mid_rst_coef_addr", 64'(CoefAddr), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    chk("mid_rst_coef_done", 64'(CoefDone), 64'd0);
    chk("mid_rst_src_ready", 64'(SrcReady), 64'd1);
    chk("mid_rst_push_in", 64'(PushIn), 64'd0);
    run_burst(27'd0, 27'd0, 27'd0, 1'b1);
    repeat (3) step(1'b0, 24'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
